// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - sequence checker for a free-running ripple counter output
//
// Purpose:
//   Brings an asynchronous ripple-counter value into the clk domain through a
//   two-flop synchronizer. Values that have settled are accepted. Each accepted
//   value is checked to be the previous accepted value plus one, modulo 2^WIDTH.
//   The block reports lock status, wrap steps and sequence errors.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   count_in   in   [WIDTH-1:0] ripple counter value, asynchronous to clk
//   enable     in   checker active when high
//   locked     out  LOCK_COUNT consecutive correct increments seen
//   err_pulse  out  one-cycle pulse per sequence error while locked
//   wrap_pulse out  one-cycle pulse on a correct all-ones -> 0 step while locked
//   last_value out  [WIDTH-1:0] most recently accepted value
//   err_count  out  [7:0] saturating error count since reset

module count_seq_checker #(
    parameter int WIDTH      = 4,
    parameter int STABLE     = 2,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             enable,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [WIDTH-1:0] last_value,
    output logic [7:0]       err_count
);

    localparam int SW = $clog2(STABLE + 1);
    localparam int RW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state, state_n;

    logic [WIDTH-1:0] s1, s2;
    logic [SW-1:0]    stab_cnt, stab_next;
    logic             first_pend;
    logic             accept;
    logic             ev;

    logic [RW-1:0]    run, run_n, run_inc;
    logic [WIDTH-1:0] ref_val, ref_n, ref_inc;
    logic             has_ref, has_ref_n;
    logic             locked_n, err_n, wrap_n;
    logic [7:0]       err_count_n;

    // The stability count is computed against s1, which becomes s2 at this
    // edge. An accepted event can therefore be registered in the same edge
    // that the count reaches STABLE.
    always_comb begin
        if (s1 != s2) begin
            stab_next = SW'(1);
        end else if (stab_cnt == SW'(STABLE)) begin
            stab_next = stab_cnt;
        end else begin
            stab_next = stab_cnt + SW'(1);
        end
        accept = enable && (state != IDLE) && (stab_next == SW'(STABLE))
                 && ((s1 != last_value) || first_pend);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            stab_cnt   <= '0;
            first_pend <= 1'b1;
            ev         <= 1'b0;
            last_value <= '0;
        end else begin
            s1       <= count_in;
            s2       <= s1;
            stab_cnt <= stab_next;
            ev       <= accept;
            if (accept) begin
                last_value <= s1;
            end
            // A value already held from before acquisition is still accepted
            // once. Otherwise a stopped counter would never produce an event.
            if (state == IDLE) begin
                first_pend <= 1'b1;
            end else if (accept) begin
                first_pend <= 1'b0;
            end
        end
    end

    // The event value is last_value. It was loaded on the same edge that raised ev.
    always_comb begin
        state_n     = state;
        run_n       = run;
        ref_n       = ref_val;
        has_ref_n   = has_ref;
        locked_n    = locked;
        err_n       = 1'b0;
        wrap_n      = 1'b0;
        err_count_n = err_count;
        run_inc     = run + RW'(1);
        ref_inc     = ref_val + WIDTH'(1);

        if (!enable) begin
            state_n   = IDLE;
            locked_n  = 1'b0;
            run_n     = '0;
            has_ref_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n   = ACQUIRE;
                    run_n     = '0;
                    has_ref_n = 1'b0;
                    locked_n  = 1'b0;
                end
                ACQUIRE: begin
                    if (ev) begin
                        ref_n     = last_value;
                        has_ref_n = 1'b1;
                        if (has_ref && (last_value == ref_inc)) begin
                            run_n = run_inc;
                            if (run_inc == RW'(LOCK_COUNT)) begin
                                state_n  = LOCKED;
                                locked_n = 1'b1;
                            end
                        end else begin
                            run_n = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (ev) begin
                        ref_n = last_value;
                        if (last_value == ref_inc) begin
                            wrap_n = (ref_val == {WIDTH{1'b1}});
                        end else begin
                            err_n       = 1'b1;
                            err_count_n = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                            locked_n    = 1'b0;
                            state_n     = ACQUIRE;
                            run_n       = '0;
                        end
                    end
                end
                default: begin
                    state_n  = IDLE;
                    locked_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            run        <= '0;
            ref_val    <= '0;
            has_ref    <= 1'b0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            run        <= run_n;
            ref_val    <= ref_n;
            has_ref    <= has_ref_n;
            locked     <= locked_n;
            err_pulse  <= err_n;
            wrap_pulse <= wrap_n;
            err_count  <= err_count_n;
        end
    end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Consumer-side monitor for the 4-bit ripple (asynchronous) counter.
- Samples the counter's free-running count output into the system clock domain and filters ripple transients.
- Verifies that accepted values advance by +1 modulo 2^WIDTH, reporting lock status, wrap events and sequence errors.
- Sits beside the ripple counter in lab top-levels and benches as a self-check block.

Parameters:
- WIDTH, 4: width of the monitored count.
- STABLE, 2: consecutive identical synchronized samples required to accept a value (≥1).
- LOCK_COUNT, 4: consecutive correct increments required to assert locked (≥1).

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- count_in, input, WIDTH: count from the ripple counter; asynchronous to clk.
- enable, input, 1: checker active when high.
- locked, output, 1: sequence tracked correctly for LOCK_COUNT increments.
- err_pulse, output, 1: one-cycle pulse per sequence error while locked.
- wrap_pulse, output, 1: one-cycle pulse on a correct (2^WIDTH−1)→0 step while locked.
- last_value, output, WIDTH: most recently accepted value.
- err_count, output, 8: errors seen since reset; saturates at 255.

Behaviour:
- Reset (rst high at an edge):
  - All outputs are 0: locked, err_pulse, wrap_pulse, last_value, err_count.
  - Synchronizer, stability counter, run counter and reference are cleared; FSM goes to IDLE.
  - Takes priority over everything, including mid-lock.
- Synchronizer: two flops, s1 then s2. No logic between them.
- Stability filter:
  - stab_cnt resets to 1 when s2 changes and increments (saturating) while s2 holds.
  - Accept event: stab_cnt reaches STABLE and s2 ≠ last_value, or this is the first acceptance since IDLE.
  - Events are a registered one-cycle strobe; last_value updates on the event.
- Latency: an event for a value first sampled by s1 at edge k fires at edge k+STABLE. Pulses and locked are registered one edge later, at edge k+STABLE+1.
- FSM states: IDLE, ACQUIRE, LOCKED.
  - IDLE:
    - Outputs locked=0; err_count held.
    - enable=1 moves to ACQUIRE, with run=0 and no reference yet.
  - ACQUIRE:
    - The first event sets the reference and does not check it.
    - Each later event: if value == ref+1 (mod 2^WIDTH), run++; otherwise run=0. In both cases ref=value.
    - When run reaches LOCK_COUNT, go to LOCKED; locked=1 from that registered edge.
  - LOCKED:
    - Event with value == ref+1: stay in LOCKED. If ref == 2^WIDTH−1 and value == 0, also pulse wrap_pulse.
    - Event with any other value: pulse err_pulse, err_count++ (saturating at 255), locked=0, go to ACQUIRE with run=0 and ref=value.
- No checks between events: a steady count (counter clock stopped) is never an error.
- Pulse rules: err_pulse and wrap_pulse are never high together, and never high for more than one cycle per event.
- enable low: in any state, go to IDLE at the next edge. locked=0, pulses suppressed; err_count and last_value are held.
- Simultaneous rst and enable: rst wins.
- Glitch rejection: a value present in s2 for fewer than STABLE cycles is never accepted.

Test Plan (clk period 20 ns; count_in steps held 8 clk unless stated; defaults WIDTH=4, STABLE=2, LOCK_COUNT=4):
- Reset: rst=1 for 2 edges with count_in=9 → all outputs 0, FSM in IDLE.
- Lock and wrap:
  - Stimulus: enable=1, drive 0,1,2,…,15,0,1.
  - locked rises 3 edges after the edge sampling value 4.
  - wrap_pulse is high exactly one cycle after 15→0.
  - err_count stays 0 and last_value tracks.
- Error:
  - Stimulus: while locked, 5→9, then 10,11,12,13.
  - err_pulse is one cycle and err_count=1.
  - locked drops on the same registered edge and reasserts after 13 is accepted.
- Ripple glitch: while locked, 7→(6 for 1 clk)→8 → no err_pulse, last_value goes 7→8, locked stays 1.
- Enable and reset mid-lock:
  - enable=0 while locked → next edge locked=0, err_count held at 1.
  - Re-enable → reacquire: lock after 4 good steps.
  - rst while locked → all outputs 0 next edge.
- Saturation: inject 300 errors (relocking between each) → err_count reaches 255 and holds; err_pulse still pulses per error.
